// File: rtl/decode_stage.sv
// RV32I decode stage (no FENCE/SYSTEM): instruction decode, integer register file
// with write-through bypass, and the D/E pipeline register with stall/flush/valid.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ValidD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            ValidE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            JalrE,
    output logic            IllegalE,
    output logic            ALUSrcAE,
    output logic            ALUSrcBE,
    output logic [1:0]      ResultSrcE,
    output logic [3:0]      ALUControlE,
    output logic [2:0]      Funct3E
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            illegal;
        logic            alu_src_a;
        logic            alu_src_b;
        logic [1:0]      result_src;
        logic [3:0]      alu_ctrl;
        logic [2:0]      funct3;
    } de_t;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = 4'b0111;
            3'b010:  alu_op = 4'b0101;
            3'b011:  alu_op = 4'b0110;
            3'b100:  alu_op = 4'b0100;
            3'b101:  alu_op = alt ? 4'b1001 : 4'b1000;
            3'b110:  alu_op = 4'b0011;
            default: alu_op = 4'b0010;
        endcase
    endfunction

    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rd1, rd2;
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [31:0]     imm32;
    logic            reg_write, mem_write, branch, jump, jalr, illegal;
    logic            alu_src_a, alu_src_b;
    logic [1:0]      result_src;
    logic [3:0]      alu_ctrl;
    de_t             de_d, de_q;

    assign opcode = InstrD[6:0];
    assign f3     = InstrD[14:12];
    assign f7     = InstrD[31:25];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (RegWriteW && RdW != 5'd0) begin
            rf_q[RdW] <= ResultW;
        end
    end

    // Same-cycle writeback wins over the stored value so RD*E never sees stale data.
    always_comb begin
        rd1 = (Rs1D == 5'd0) ? '0 : rf_q[Rs1D];
        rd2 = (Rs2D == 5'd0) ? '0 : rf_q[Rs2D];
        if (RegWriteW && RdW != 5'd0 && RdW == Rs1D) rd1 = ResultW;
        if (RegWriteW && RdW != 5'd0 && RdW == Rs2D) rd2 = ResultW;
    end

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jalr       = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        result_src = 2'b00;
        alu_ctrl   = ALU_ADD;
        imm32      = '0;
        case (opcode)
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src_b  = 1'b1;
                result_src = 2'b01;
                imm32      = {{20{InstrD[31]}}, InstrD[31:20]};
                illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src_b = 1'b1;
                imm32     = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                illegal   = f3[2] || (f3 == 3'b011);
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_ctrl  = alu_op(f3, f7[5]);
                illegal   = !((f7 == 7'b0000000) ||
                              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_I: begin
                // funct7 bits are immediate bits except for shifts.
                reg_write = 1'b1;
                alu_src_b = 1'b1;
                imm32     = {{20{InstrD[31]}}, InstrD[31:20]};
                alu_ctrl  = alu_op(f3, (f3 == 3'b101) && f7[5]);
                illegal   = (f3 == 3'b001 && f7 != 7'b0000000) ||
                            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            OP_BRANCH: begin
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
                imm32    = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
                illegal  = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
                imm32      = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                jalr       = 1'b1;
                alu_src_b  = 1'b1;
                result_src = 2'b10;
                imm32      = {{20{InstrD[31]}}, InstrD[31:20]};
                illegal    = (f3 != 3'b000);
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src_b = 1'b1;
                alu_ctrl  = ALU_PASSB;
                imm32     = {InstrD[31:12], 12'b0};
            end
            OP_AUIPC: begin
                reg_write = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 1'b1;
                imm32     = {InstrD[31:12], 12'b0};
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            reg_write = 1'b0;
            mem_write = 1'b0;
            branch    = 1'b0;
            jump      = 1'b0;
            jalr      = 1'b0;
        end
    end

    always_comb begin
        de_d            = '0;
        de_d.valid      = ValidD;
        de_d.pc         = PCD;
        de_d.pc4        = PCPlus4D;
        de_d.imm        = XLEN'(signed'(imm32));
        de_d.rd1        = rd1;
        de_d.rd2        = rd2;
        de_d.rs1        = Rs1D;
        de_d.rs2        = Rs2D;
        de_d.rd         = InstrD[11:7];
        de_d.reg_write  = reg_write & ValidD;
        de_d.mem_write  = mem_write & ValidD;
        de_d.branch     = branch & ValidD;
        de_d.jump       = jump & ValidD;
        de_d.jalr       = jalr & ValidD;
        de_d.illegal    = illegal & ValidD;
        de_d.alu_src_a  = alu_src_a;
        de_d.alu_src_b  = alu_src_b;
        de_d.result_src = result_src;
        de_d.alu_ctrl   = alu_ctrl;
        de_d.funct3     = f3;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     de_q <= '0;
        else if (FlushE)  de_q <= '0;
        else if (!StallE) de_q <= de_d;
    end

    assign ValidE      = de_q.valid;
    assign PCE         = de_q.pc;
    assign PCPlus4E    = de_q.pc4;
    assign ImmExtE     = de_q.imm;
    assign RD1E        = de_q.rd1;
    assign RD2E        = de_q.rd2;
    assign Rs1E        = de_q.rs1;
    assign Rs2E        = de_q.rs2;
    assign RdE         = de_q.rd;
    assign RegWriteE   = de_q.reg_write;
    assign MemWriteE   = de_q.mem_write;
    assign BranchE     = de_q.branch;
    assign JumpE       = de_q.jump;
    assign JalrE       = de_q.jalr;
    assign IllegalE    = de_q.illegal;
    assign ALUSrcAE    = de_q.alu_src_a;
    assign ALUSrcBE    = de_q.alu_src_b;
    assign ResultSrcE  = de_q.result_src;
    assign ALUControlE = de_q.alu_ctrl;
    assign Funct3E     = de_q.funct3;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_decode_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD, PCPlus4D;
    logic            ValidD, StallE, FlushE, RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic [4:0]      Rs1D, Rs2D;
    logic            ValidE;
    logic [XLEN-1:0] PCE, PCPlus4E, ImmExtE, RD1E, RD2E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic            RegWriteE, MemWriteE, BranchE, JumpE, JalrE, IllegalE;
    logic            ALUSrcAE, ALUSrcBE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUControlE;
    logic [2:0]      Funct3E;

    int tests = 0;
    int fails = 0;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .RegWriteW(RegWriteW),
        .RdW(RdW), .ResultW(ResultW), .Rs1D(Rs1D), .Rs2D(Rs2D), .ValidE(ValidE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .RD1E(RD1E), .RD2E(RD2E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .IllegalE(IllegalE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .Funct3E(Funct3E)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic valid);
        InstrD   = instr;
        ValidD   = valid;
        PCD      = 32'h0000_0100;
        PCPlus4D = 32'h0000_0104;
    endtask

    initial begin
        reset_n = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0; ValidD = 1'b0;
        StallE = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        #12;
        check("rst_valid", ValidE, 0);
        check("rst_imm", ImmExtE, 0);
        check("rst_regwrite", RegWriteE, 0);
        reset_n = 1'b1;

        // addi x5,x0,-1
        present(32'hFFF00293, 1'b1);
        #1;
        check("rs1d_zero_lat", Rs1D, 0);
        check("rs2d_zero_lat", Rs2D, 31);
        tick();
        check("addi_rd", RdE, 5);
        check("addi_imm", ImmExtE, 32'hFFFF_FFFF);
        check("addi_alu", ALUControlE, 4'b0000);
        check("addi_srcb", ALUSrcBE, 1);
        check("addi_regwrite", RegWriteE, 1);
        check("addi_resultsrc", ResultSrcE, 2'b00);
        check("addi_valid", ValidE, 1);
        check("addi_pc", PCE, 32'h100);
        check("addi_pc4", PCPlus4E, 32'h104);

        // add x1,x3,x3 with same-cycle write of x3
        present(32'h003180B3, 1'b1);
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h0000_1234;
        tick();
        check("bypass_rd1", RD1E, 32'h1234);
        check("bypass_rd2", RD2E, 32'h1234);
        // add x4,x0,x3 with write to x0 attempted
        present(32'h00300233, 1'b1);
        RdW = 5'd0; ResultW = 32'h0000_DEAD;
        tick();
        check("x0_bypass_rd1", RD1E, 0);
        check("stored_x3_rd2", RD2E, 32'h1234);
        RegWriteW = 1'b0;
        tick();
        check("x0_after_write", RD1E, 0);

        // bne x1,x2,-4
        present(32'hFE209EE3, 1'b1);
        tick();
        check("bne_imm", ImmExtE, 32'hFFFF_FFFC);
        check("bne_branch", BranchE, 1);
        check("bne_f3", Funct3E, 3'b001);
        check("bne_alu", ALUControlE, 4'b0001);
        check("bne_regwrite", RegWriteE, 0);

        // jalr x1,4(x2)
        present(32'h004100E7, 1'b1);
        tick();
        check("jalr_jalr", JalrE, 1);
        check("jalr_resultsrc", ResultSrcE, 2'b10);
        check("jalr_imm", ImmExtE, 4);
        check("jalr_rs1", Rs1E, 2);

        // sub x1,x2,x3 ; srai x1,x2,3 ; xori x1,x2,-1 ; sw x2,8(x1)
        present(32'h403100B3, 1'b1);
        tick();
        check("sub_alu", ALUControlE, 4'b0001);
        present(32'h40315093, 1'b1);
        tick();
        check("srai_alu", ALUControlE, 4'b1001);
        check("srai_illegal", IllegalE, 0);
        present(32'hFFF14093, 1'b1);
        tick();
        check("xori_alu", ALUControlE, 4'b0100);
        check("xori_illegal", IllegalE, 0);
        present(32'h0020A423, 1'b1);
        tick();
        check("sw_memwrite", MemWriteE, 1);
        check("sw_imm", ImmExtE, 8);
        check("sw_regwrite", RegWriteE, 0);

        // mul (unsupported funct7) and branch funct3=010
        present(32'h02208033, 1'b1);
        tick();
        check("mul_illegal", IllegalE, 1);
        check("mul_regwrite", RegWriteE, 0);
        present(32'h0020A063, 1'b1);
        tick();
        check("br010_illegal", IllegalE, 1);
        check("br010_branch", BranchE, 0);

        // ValidD=0: datapath loads, controls don't
        present(32'hFFF00293, 1'b0);
        tick();
        check("bubbleD_valid", ValidE, 0);
        check("bubbleD_regwrite", RegWriteE, 0);
        check("bubbleD_imm", ImmExtE, 32'hFFFF_FFFF);

        // lui x7,0x12345 then stall for two edges
        present(32'h123453B7, 1'b1);
        tick();
        check("lui_imm", ImmExtE, 32'h1234_5000);
        check("lui_alu", ALUControlE, 4'b1010);
        check("lui_rd", RdE, 7);
        StallE = 1'b1;
        present(32'hFFF00293, 1'b1);
        tick();
        check("stall1_imm", ImmExtE, 32'h1234_5000);
        tick();
        check("stall2_rd", RdE, 7);
        check("stall2_alu", ALUControlE, 4'b1010);
        // flush+stall, with a register write that must still land
        FlushE = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h0000_CAFE;
        tick();
        check("flush_valid", ValidE, 0);
        check("flush_regwrite", RegWriteE, 0);
        check("flush_imm", ImmExtE, 0);
        FlushE = 1'b0; StallE = 1'b0; RegWriteW = 1'b0;
        // add x10,x9,x0
        present(32'h00048533, 1'b1);
        tick();
        check("flush_rf_write", RD1E, 32'hCAFE);

        // all-zero instruction
        present(32'h00000000, 1'b1);
        tick();
        check("zero_illegal", IllegalE, 1);
        check("zero_regwrite", RegWriteE, 0);
        check("zero_memwrite", MemWriteE, 0);
        check("zero_valid", ValidE, 1);

        // async reset between edges
        present(32'h123453B7, 1'b1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_imm", ImmExtE, 0);
        check("async_rst_valid", ValidE, 0);
        check("async_rst_rd", RdE, 0);
        check("async_rst_regwrite", RegWriteE, 0);
        #1;
        reset_n = 1'b1;
        present(32'h00048533, 1'b1);
        tick();
        check("post_rst_x9", RD1E, 0);
        check("post_rst_valid", ValidE, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
